// File: rtl/dds_pkg.sv
// Shared definitions for the DDS stream blocks.
//   DDS_CHANNEL / DATA_WIDTH : default lanes per wide word and bits per lane
//   clog2_min1               : counter width helper that never returns 0
//   DDS_LANE(word, k, w)     : lane k of a packed wide word, lane 0 in the LSBs
`ifndef DDS_LANE
`define DDS_LANE(word, k, w) word[(k)*(w) +: (w)]
`endif

package dds_pkg;

    localparam int DDS_CHANNEL = 8;
    localparam int DATA_WIDTH  = 16;

    // Width needed to count 0..value-1; a single-state counter still gets one bit.
    function automatic int clog2_min1(input int value);
        int result;
        if (value <= 2) begin
            result = 1;
        end else begin
            result = $clog2(value);
        end
        return result;
    endfunction

endpackage

// File: rtl/dds_word_buffer.sv
// Two-entry word buffer: an active word being serialised and a hold word
// queued behind it.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load_i          : a word is accepted from the source this cycle
//   data_i          : the accepted word
//   last_xfer_i     : the last lane of the active word transfers this cycle
//   act_data_o      : active word
//   act_valid_o     : active word present
//   hold_valid_o    : hold word present (source must be stalled)
module dds_word_buffer
    import dds_pkg::*;
#(
    parameter int word_width = DDS_CHANNEL * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [word_width-1:0] data_i,
    input  logic                  last_xfer_i,
    output logic [word_width-1:0] act_data_o,
    output logic                  act_valid_o,
    output logic                  hold_valid_o
);

    logic [word_width-1:0] act_data_q,  act_data_d;
    logic [word_width-1:0] hold_data_q, hold_data_d;
    logic                  act_valid_q, act_valid_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  act_free_s;

    // Active slot is free at this edge if empty or finishing its last lane.
    assign act_free_s = ~act_valid_q | last_xfer_i;

    // Load control. load_i is never high while hold is occupied, so a hold
    // reload and a direct input load cannot collide.
    always_comb begin
        act_data_d   = act_data_q;
        hold_data_d  = hold_data_q;
        act_valid_d  = act_valid_q;
        hold_valid_d = hold_valid_q;
        if (act_free_s) begin
            if (hold_valid_q) begin
                act_data_d   = hold_data_q;
                act_valid_d  = 1'b1;
                hold_valid_d = 1'b0;
            end else if (load_i) begin
                act_data_d  = data_i;
                act_valid_d = 1'b1;
            end else begin
                act_valid_d = 1'b0;
            end
        end else begin
            if (load_i) begin
                hold_data_d  = data_i;
                hold_valid_d = 1'b1;
            end else begin
                hold_valid_d = hold_valid_q;
            end
        end
    end

    // Buffer state registers; data clears too so outputs read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data_q   <= '0;
            hold_data_q  <= '0;
            act_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            act_data_q   <= act_data_d;
            hold_data_q  <= hold_data_d;
            act_valid_q  <= act_valid_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign act_data_o   = act_data_q;
    assign act_valid_o  = act_valid_q;
    assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/dds_lane_serializer.sv
// Wide-to-narrow AXI-Stream serialiser: emits each dds_channel-lane input
// word as dds_channel single-sample beats, lane 0 first.
//   clk, rst_n     : clock, asynchronous active-low reset
//   s_axis_*       : wide input stream (lane k at bits [k*data_width +: data_width])
//   m_axis_tdata   : serial sample
//   m_axis_tvalid  : sample valid
//   m_axis_tready  : downstream accept
//   m_axis_tuser   : lane index of the current sample
//   m_axis_tlast   : last sample of each frame_len-sample frame
// All outputs are driven from registers only.
module dds_lane_serializer
    import dds_pkg::*;
#(
    parameter int dds_channel = DDS_CHANNEL,
    parameter int data_width  = DATA_WIDTH,
    parameter int frame_len   = 32768
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [data_width*dds_channel-1:0] s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [data_width-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [$clog2(dds_channel)-1:0]    m_axis_tuser,
    output logic                              m_axis_tlast
);

    localparam int LW = clog2_min1(dds_channel);
    localparam int FW = clog2_min1(frame_len);
    localparam logic [LW-1:0] LANE_LAST  = LW'(dds_channel - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(frame_len - 1);

    logic [LW-1:0]                     lane_q, lane_d;
    logic [FW-1:0]                     frame_q, frame_d;
    logic                              ready_en_q;
    logic [data_width*dds_channel-1:0] act_data_s;
    logic                              act_valid_s;
    logic                              hold_valid_s;
    logic                              accept_s;
    logic                              xfer_s;
    logic                              last_xfer_s;
    logic [data_width-1:0]             lane_s [dds_channel];

    assign s_axis_tready = ready_en_q & ~hold_valid_s;
    assign accept_s      = s_axis_tvalid & s_axis_tready;
    assign xfer_s        = act_valid_s & m_axis_tready;
    assign last_xfer_s   = xfer_s & (lane_q == LANE_LAST);

    dds_word_buffer #(
        .word_width (data_width * dds_channel)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (accept_s),
        .data_i       (s_axis_tdata),
        .last_xfer_i  (last_xfer_s),
        .act_data_o   (act_data_s),
        .act_valid_o  (act_valid_s),
        .hold_valid_o (hold_valid_s)
    );

    for (genvar k = 0; k < dds_channel; k++) begin : g_lane
        assign lane_s[k] = `DDS_LANE(act_data_s, k, data_width);
    end

    // Lane and frame counters advance only on an output transfer.
    always_comb begin
        lane_d  = lane_q;
        frame_d = frame_q;
        if (xfer_s) begin
            if (lane_q == LANE_LAST) begin
                lane_d = '0;
            end else begin
                lane_d = lane_q + LW'(1);
            end
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end else begin
            lane_d  = lane_q;
            frame_d = frame_q;
        end
    end

    // Counter registers; ready_en holds off input for one cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q     <= '0;
            frame_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            frame_q    <= frame_d;
            ready_en_q <= 1'b1;
        end
    end

    assign m_axis_tvalid = act_valid_s;
    assign m_axis_tdata  = lane_s[lane_q];
    assign m_axis_tuser  = lane_q;
    assign m_axis_tlast  = act_valid_s & (frame_q == FRAME_LAST);

endmodule

// File: tb/tb_dds_lane_serializer.sv
module tb_dds_lane_serializer;

    localparam int DC = 8;
    localparam int DW = 16;
    localparam int FL = 16;

    logic              clk;
    logic              rst_n;
    logic [DC*DW-1:0]  s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [2:0]        m_tuser;
    logic              m_tlast;

    dds_lane_serializer #(
        .dds_channel (DC),
        .data_width  (DW),
        .frame_len   (FL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: samples still owed to the output, in order.
    logic [DW-1:0]    q[$];
    int               out_cnt;
    bit               rdy_m;
    int               words_left;
    logic [DC*DW-1:0] cur_word;
    int               checks;
    int               errors;

    function automatic logic [DC*DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_valid;
        int words_held;
        exp_valid  = (q.size() != 0);
        words_held = (q.size() + DC - 1) / DC;
        chk("m_tvalid", 32'(m_tvalid), 32'(exp_valid));
        chk("s_tready", 32'(s_tready), 32'(rdy_m && (words_held < 2)));
        if (exp_valid) begin
            chk("m_tdata", 32'(m_tdata), 32'(q[0]));
            chk("m_tuser", 32'(m_tuser), 32'(out_cnt % DC));
            chk("m_tlast", 32'(m_tlast), 32'((out_cnt % FL) == FL - 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_tdata"},  32'(m_tdata),  32'd0);
        chk({tag, "_tuser"},  32'(m_tuser),  32'd0);
        chk({tag, "_tlast"},  32'(m_tlast),  32'd0);
        chk({tag, "_sready"}, 32'(s_tready), 32'd0);
    endtask

    // One clock: drive source, note handshakes, advance model, compare.
    task automatic tick();
        bit acc;
        bit xf;
        s_tvalid = (words_left > 0);
        s_tdata  = cur_word;
        acc = s_tvalid && s_tready;
        xf  = m_tvalid && m_tready;
        @(posedge clk);
        #1;
        if (xf && q.size() != 0) begin
            void'(q.pop_front());
            out_cnt++;
        end
        if (acc) begin
            for (int k = 0; k < DC; k++) q.push_back(cur_word[k*DW +: DW]);
            words_left--;
            cur_word = rand_word();
        end
        rdy_m = 1'b1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n      = 1'b0;
        s_tvalid   = 1'b0;
        words_left = 0;
        #1;
        q.delete();
        out_cnt = 0;
        rdy_m   = 1'b0;
        check_reset_outputs("rst_async");
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
        #1;
        chk("rst_release_sready", 32'(s_tready), 32'd0);
    endtask

    initial begin
        int run;
        int best_run;
        int start_cnt;
        int n;
        bit saw_full;
        int last_pos[$];

        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        m_tready   = 1'b0;
        words_left = 0;
        out_cnt    = 0;
        rdy_m      = 1'b0;
        cur_word   = rand_word();
        #1;

        // 1: reset, then one cycle with s_tready low
        do_reset(10);
        tick();

        // 2: single word with lanes 0..7
        m_tready = 1'b1;
        for (int k = 0; k < DC; k++) cur_word[k*DW +: DW] = DW'(k);
        words_left = 1;
        tick();
        for (int i = 0; i < DC; i++) begin
            chk("t2_data", 32'(m_tdata), 32'(i));
            chk("t2_user", 32'(m_tuser), 32'(i));
            tick();
        end
        chk("t2_valid_drop", 32'(m_tvalid), 32'd0);

        // 3: 32 back-to-back random words, output must never bubble
        words_left = 32;
        run        = 0;
        best_run   = 0;
        for (int c = 0; c < 320 && (words_left > 0 || q.size() != 0); c++) begin
            tick();
            if (m_tvalid) begin
                run++;
                if (run > best_run) best_run = run;
            end else begin
                run = 0;
            end
        end
        chk("t3_continuous", 32'(best_run), 32'(32 * DC));
        chk("t3_drained", 32'(q.size()), 32'd0);

        // 4: downstream toggling, source always valid
        words_left = 6;
        start_cnt  = out_cnt;
        saw_full   = 1'b0;
        for (int c = 0; c < 200 && (words_left > 0 || q.size() != 0); c++) begin
            m_tready = ~m_tready;
            tick();
            if (!s_tready && rdy_m) saw_full = 1'b1;
        end
        chk("t4_saw_full", 32'(saw_full), 32'd1);
        chk("t4_count", 32'(out_cnt - start_cnt), 32'(6 * DC));

        // 6: fill active + hold, transfer lanes 0..3, reset mid-word
        m_tready   = 1'b0;
        words_left = 2;
        repeat (3) tick();
        chk("t6_full_sready", 32'(s_tready), 32'd0);
        m_tready = 1'b1;
        repeat (4) tick();
        chk("t6_lane4", 32'(m_tuser), 32'd4);
        do_reset(3);
        tick();

        // 5: frame markers on samples 15 and 31 after the reset
        words_left = 4;
        tick();
        chk("t6_first_lane", 32'(m_tuser), 32'd0);
        chk("t6_first_valid", 32'(m_tvalid), 32'd1);
        n = 0;
        for (int c = 0; c < 80 && (words_left > 0 || q.size() != 0); c++) begin
            if (m_tvalid && m_tlast) last_pos.push_back(n);
            if (m_tvalid) n++;
            tick();
        end
        chk("t5_samples", 32'(n), 32'(4 * DC));
        chk("t5_tlast_count", 32'(last_pos.size()), 32'd2);
        if (last_pos.size() == 2) begin
            chk("t5_tlast_first", 32'(last_pos[0]), 32'd15);
            chk("t5_tlast_second", 32'(last_pos[1]), 32'd31);
        end else begin
            chk("t5_tlast_shape", 32'(last_pos.size()), 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
